mvm_config_loader: RTL and testbench

- DMA-style sequencer that preloads MVM tiles over the AXI-S mesh from a local word memory.
- Accepts load descriptors; each descriptor names an MVM node, a payload type (instruction or weight), a memory base address and a word count.
- Streams the words as NoC packets, building the tuser sideband (appended above tdata) that MVM tiles decode.
- Sits at the loader node of the mesh and replaces bench-driven instruction/weight injection in hardware bring-up.

---
 rtl/mvm_config_loader.sv | 194 +++++++++++++++++++
 tb/tb_mvm_config_loader.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_config_loader.sv
// Descriptor-driven sequencer that reads words from local memory and streams them
// to an MVM tile as AXI-S beats carrying the tile's tuser sideband.
module mvm_config_loader #(
  parameter int unsigned DATAW = 512,
  parameter int unsigned USERW = 75,
  parameter int unsigned IDW   = 2,
  parameter int unsigned DESTW = 4,
  parameter int unsigned ADDRW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  logic                   desc_type,
  input  logic [DESTW-1:0]       desc_node,
  input  logic [5:0]             desc_dpe,
  input  logic [ADDRW-1:0]       desc_base,
  input  logic [9:0]             desc_len,
  input  logic                   desc_last,
  output logic                   mem_ren,
  output logic [ADDRW-1:0]       mem_raddr,
  input  logic [DATAW-1:0]       mem_rdata,
  output logic                   axis_tx_tvalid,
  input  logic                   axis_tx_tready,
  output logic [DATAW+USERW-1:0] axis_tx_tdata,
  output logic [IDW-1:0]         axis_tx_tid,
  output logic [DESTW-1:0]       axis_tx_tdest,
  output logic                   axis_tx_tlast,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            beat_count
);

  localparam int unsigned LENW      = 10;
  localparam int unsigned DPEW      = 6;
  localparam int unsigned RFAW      = 9;
  localparam int unsigned CMD_LSB   = 9;
  localparam int unsigned RF_EN_LSB = 11;
  localparam int unsigned RFENW     = USERW - RF_EN_LSB;
  localparam int unsigned INSTRW    = 32;
  localparam int unsigned TXW       = DATAW + USERW;
  localparam int unsigned CNTW      = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_SEND  = 2'd3;

  localparam logic [1:0] CMD_WEIGHT = 2'b11;

  typedef struct packed {
    logic             typ;
    logic [DESTW-1:0] node;
    logic [DPEW-1:0]  dpe;
    logic [ADDRW-1:0] base;
    logic [LENW-1:0]  len;
    logic             last;
  } desc_t;

  logic [1:0]       state_q, state_d;
  desc_t            desc_q, desc_d;
  logic [LENW-1:0]  idx_q, idx_d;
  logic             mem_ren_q, mem_ren_d;
  logic [ADDRW-1:0] mem_raddr_q, mem_raddr_d;
  logic             tvalid_q, tvalid_d;
  logic [TXW-1:0]   tdata_q, tdata_d;
  logic             tlast_q, tlast_d;
  logic             desc_ready_q, desc_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNTW-1:0]  beat_count_q, beat_count_d;

  logic [USERW-1:0] beat_user;
  logic [DATAW-1:0] beat_pay;
  logic             is_last_word;

  assign is_last_word = (idx_q == desc_q.len - LENW'(1));

  // Beat assembly from the word returned by memory in LOAD.
  always_comb begin : beat_build
    beat_user = '0;
    beat_pay  = DATAW'(mem_rdata[INSTRW-1:0]);
    if (desc_q.typ) begin
      beat_pay                              = mem_rdata;
      beat_user[USERW-1:RF_EN_LSB]          = RFENW'(1) << desc_q.dpe;
      beat_user[RF_EN_LSB-1:CMD_LSB]        = CMD_WEIGHT;
      beat_user[RFAW-1:0]                   = idx_q[RFAW-1:0];
    end
  end

  always_comb begin : next_state
    state_d      = state_q;
    desc_d       = desc_q;
    idx_d        = idx_q;
    mem_ren_d    = 1'b0;
    mem_raddr_d  = mem_raddr_q;
    tvalid_d     = tvalid_q;
    tdata_d      = tdata_q;
    tlast_d      = tlast_q;
    done_d       = 1'b0;
    beat_count_d = beat_count_q;

    case (state_q)
      S_IDLE: begin
        if (desc_valid) begin
          desc_d.typ  = desc_type;
          desc_d.node = desc_node;
          desc_d.dpe  = desc_dpe;
          desc_d.base = desc_base;
          desc_d.len  = desc_len;
          desc_d.last = desc_last;
          idx_d       = '0;
          if (desc_len != '0) begin
            state_d     = S_FETCH;
            mem_ren_d   = 1'b1;
            mem_raddr_d = desc_base;
          end else begin
            done_d = desc_last;
          end
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        tdata_d  = {beat_user, beat_pay};
        tlast_d  = is_last_word;
        tvalid_d = 1'b1;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (axis_tx_tready) begin
          tvalid_d     = 1'b0;
          beat_count_d = beat_count_q + CNTW'(1);
          if (is_last_word) begin
            state_d = S_IDLE;
            done_d  = desc_q.last;
          end else begin
            idx_d       = idx_q + LENW'(1);
            state_d     = S_FETCH;
            mem_ren_d   = 1'b1;
            // Address arithmetic wraps modulo the memory size.
            mem_raddr_d = desc_q.base + ADDRW'(idx_q + LENW'(1));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    desc_ready_d = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      desc_q       <= '0;
      idx_q        <= '0;
      mem_ren_q    <= 1'b0;
      mem_raddr_q  <= '0;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tlast_q      <= 1'b0;
      desc_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      beat_count_q <= '0;
    end else begin
      state_q      <= state_d;
      desc_q       <= desc_d;
      idx_q        <= idx_d;
      mem_ren_q    <= mem_ren_d;
      mem_raddr_q  <= mem_raddr_d;
      tvalid_q     <= tvalid_d;
      tdata_q      <= tdata_d;
      tlast_q      <= tlast_d;
      desc_ready_q <= desc_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign desc_ready     = desc_ready_q;
  assign mem_ren        = mem_ren_q;
  assign mem_raddr      = mem_raddr_q;
  assign axis_tx_tvalid = tvalid_q;
  assign axis_tx_tdata  = tdata_q;
  assign axis_tx_tid    = '0;
  assign axis_tx_tdest  = desc_q.node;
  assign axis_tx_tlast  = tlast_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign beat_count     = beat_count_q;

endmodule

// File: tb/tb_mvm_config_loader.sv
// Bench for mvm_config_loader: descriptor table, hand-built corner sequences and
// randomized traffic checked against a beat-list model of each descriptor.
module tb_mvm_config_loader;
  localparam int unsigned DATAW = 512;
  localparam int unsigned USERW = 75;
  localparam int unsigned IDW   = 2;
  localparam int unsigned DESTW = 4;
  localparam int unsigned ADDRW = 16;
  localparam int unsigned TXW   = DATAW + USERW;

  logic clk, rst;
  logic desc_valid, desc_ready, desc_type, desc_last;
  logic [DESTW-1:0] desc_node;
  logic [5:0] desc_dpe;
  logic [ADDRW-1:0] desc_base;
  logic [9:0] desc_len;
  logic mem_ren;
  logic [ADDRW-1:0] mem_raddr;
  logic [DATAW-1:0] mem_rdata;
  logic tvalid, tready, tlast, busy, done;
  logic [TXW-1:0] tdata;
  logic [IDW-1:0] tid;
  logic [DESTW-1:0] tdest;
  logic [31:0] beat_count;

  mvm_config_loader #(.DATAW(DATAW), .USERW(USERW), .IDW(IDW), .DESTW(DESTW), .ADDRW(ADDRW)) dut (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_type(desc_type),
    .desc_node(desc_node), .desc_dpe(desc_dpe), .desc_base(desc_base),
    .desc_len(desc_len), .desc_last(desc_last),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .axis_tx_tvalid(tvalid), .axis_tx_tready(tready), .axis_tx_tdata(tdata),
    .axis_tx_tid(tid), .axis_tx_tdest(tdest), .axis_tx_tlast(tlast),
    .busy(busy), .done(done), .beat_count(beat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Memory contents: low word is address+0xA0, upper words a hash of the address.
  function automatic logic [DATAW-1:0] mem_word(input logic [ADDRW-1:0] a);
    logic [DATAW-1:0] w;
    for (int k = 0; k < DATAW / 32; k++)
      w[k*32 +: 32] = (k == 0) ? 32'(a) + 32'hA0
                               : (32'(a) * 32'h9E3779B1) ^ (32'(k) << 20) ^ 32'h5A5A_0000;
    return w;
  endfunction

  // Memory answers one cycle after a read; otherwise it returns junk.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem_word(mem_raddr);
    else         mem_rdata <= {16{$urandom}};
  end

  typedef struct {
    logic [TXW-1:0]   data;
    logic [DESTW-1:0] dest;
    logic             last;
    logic             prog_last;
  } beat_t;
  beat_t exp_q[$];

  // Each accepted descriptor becomes its full list of expected beats.
  task automatic model_accept(input logic typ, input logic [DESTW-1:0] node, input logic [5:0] dpe,
                              input logic [ADDRW-1:0] base, input logic [9:0] len, input logic last);
    for (int i = 0; i < int'(len); i++) begin
      beat_t b;
      logic [DATAW-1:0] w;
      w = mem_word(base + ADDRW'(i));
      if (typ) b.data = {64'(1) << dpe, 2'b11, 9'(i), w};
      else     b.data = {75'b0, 480'b0, w[31:0]};
      b.dest = node;
      b.last = (i == int'(len) - 1);
      b.prog_last = last;
      exp_q.push_back(b);
    end
  endtask

  int cyc = 0, acc_cyc = 0, done_cyc = 0, done_seen = 0, rec_beats = 0;
  int hs_q[$];
  logic [31:0] model_cnt = 0;
  logic [31:0] rec_first;
  logic [USERW-1:0] rec_user;
  bit done_due = 0, mon_ev, prev_v = 0, prev_hs = 0;
  logic [TXW-1:0] prev_data;
  logic [DESTW-1:0] prev_dest;
  logic prev_last;
  beat_t mb;

  // Cycle monitor: beat scoreboard, hold-while-stalled, done timing, counters.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_cnt = 0;
      done_due = 0;
      prev_v = 0;
      prev_hs = 0;
    end else begin
      cyc++;
      mon_ev = 0;
      chk("done_timing", 640'(done), 640'(done_due));
      chk("ready_vs_busy", 640'(desc_ready), 640'(!busy));
      chk("beat_count", 640'(beat_count), 640'(model_cnt));
      if (prev_v && !prev_hs) begin
        chk("hold_valid", 640'(tvalid), 640'(1'b1));
        chk("hold_data", 640'(tdata), 640'(prev_data));
        chk("hold_dest", 640'(tdest), 640'(prev_dest));
        chk("hold_last", 640'(tlast), 640'(prev_last));
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got beat %0h want no beat", tdata);
        end else begin
          mb = exp_q.pop_front();
          chk("beat_data", 640'(tdata), 640'(mb.data));
          chk("beat_dest", 640'(tdest), 640'(mb.dest));
          chk("beat_last", 640'(tlast), 640'(mb.last));
          chk("beat_tid", 640'(tid), 640'(0));
          mon_ev = mb.last && mb.prog_last;
        end
        model_cnt++;
        hs_q.push_back(cyc);
        rec_beats++;
        if (rec_beats == 1) rec_first = tdata[31:0];
        rec_user = tdata[TXW-1:DATAW];
      end
      if (desc_valid && desc_ready) begin
        model_accept(desc_type, desc_node, desc_dpe, desc_base, desc_len, desc_last);
        acc_cyc = cyc;
        if (desc_len == 0 && desc_last) mon_ev = 1;
      end
      if (done) begin
        done_seen++;
        done_cyc = cyc;
      end
      done_due  = mon_ev;
      prev_v    = tvalid;
      prev_hs   = tvalid && tready;
      prev_data = tdata;
      prev_dest = tdest;
      prev_last = tlast;
    end
  end

  task automatic send_desc(input logic typ, input logic [DESTW-1:0] node, input logic [5:0] dpe,
                           input logic [ADDRW-1:0] base, input logic [9:0] len, input logic last);
    bit ok = 0;
    @(posedge clk); #1;
    desc_type = typ; desc_node = node; desc_dpe = dpe;
    desc_base = base; desc_len = len; desc_last = last;
    desc_valid = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (desc_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: got desc_ready=%0d want 1", desc_ready);
    end
    @(posedge clk); #1;
    desc_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && !desc_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL idle_timeout: got busy=%0d pending=%0d want idle", busy, exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic typ; logic [3:0] node; logic [5:0] dpe; logic [15:0] base; logic [9:0] len; logic last;
    int exp_beats; logic [31:0] exp_lo; logic [USERW-1:0] exp_user; int exp_done;
  } vec_t;
  vec_t vecs[5];

  int d0, b0;
  logic [TXW-1:0] snap_data;
  logic [DESTW-1:0] snap_dest;
  logic snap_last;
  bit stop_rand, got;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; desc_valid = 1'b0; desc_type = 1'b0; desc_node = '0; desc_dpe = '0;
    desc_base = '0; desc_len = '0; desc_last = 1'b0; tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_desc_ready", 640'(desc_ready), 640'(1'b1));
    chk("rst_busy", 640'(busy), 640'(1'b0));
    chk("rst_tvalid", 640'(tvalid), 640'(1'b0));
    chk("rst_done", 640'(done), 640'(1'b0));
    chk("rst_mem_ren", 640'(mem_ren), 640'(1'b0));
    chk("rst_beat_count", 640'(beat_count), 640'(0));
    chk("rst_tdata", 640'(tdata), 640'(0));
    chk("rst_tdest_tlast", 640'({tdest, tlast}), 640'(0));
    @(posedge clk); #1 rst = 1'b0;

    vecs[0] = '{typ:0, node:2,  dpe:0,  base:16'h0010, len:3,   last:1, exp_beats:3,
                exp_lo:32'hB0,    exp_user:'0, exp_done:1};
    vecs[1] = '{typ:1, node:9,  dpe:5,  base:16'h0000, len:2,   last:1, exp_beats:2,
                exp_lo:32'hA0,    exp_user:{64'h20, 2'b11, 9'd1}, exp_done:1};
    vecs[2] = '{typ:0, node:1,  dpe:0,  base:16'h0000, len:0,   last:1, exp_beats:0,
                exp_lo:32'h0,     exp_user:'0, exp_done:1};
    vecs[3] = '{typ:1, node:15, dpe:63, base:16'hFFFF, len:512, last:0, exp_beats:512,
                exp_lo:32'h1009F, exp_user:{64'h8000_0000_0000_0000, 2'b11, 9'd511}, exp_done:0};
    vecs[4] = '{typ:1, node:3,  dpe:0,  base:16'h1234, len:1,   last:1, exp_beats:1,
                exp_lo:32'h12D4,  exp_user:{64'h1, 2'b11, 9'd0}, exp_done:1};

    for (int v = 0; v < 5; v++) begin
      d0 = done_seen;
      rec_beats = 0;
      tready = 1'b1;
      send_desc(vecs[v].typ, vecs[v].node, vecs[v].dpe, vecs[v].base, vecs[v].len, vecs[v].last);
      wait_idle();
      chk("vec_beats", 640'(rec_beats), 640'(vecs[v].exp_beats));
      if (vecs[v].exp_beats > 0) begin
        chk("vec_first_lo32", 640'(rec_first), 640'(vecs[v].exp_lo));
        chk("vec_last_tuser", 640'(rec_user), 640'(vecs[v].exp_user));
      end
      chk("vec_done_count", 640'(done_seen - d0), 640'(vecs[v].exp_done));
    end

    // Instruction burst at full rate: beats 3 cycles apart, done right after the last.
    hs_q.delete();
    b0 = int'(model_cnt);
    send_desc(1'b0, 4'd2, 6'd0, 16'h0010, 10'd3, 1'b1);
    wait_idle();
    chk("rate_beats", 640'(hs_q.size()), 640'(3));
    if (hs_q.size() == 3) begin
      chk("rate_first_latency", 640'(hs_q[0] - acc_cyc), 640'(3));
      chk("rate_gap1", 640'(hs_q[1] - hs_q[0]), 640'(3));
      chk("rate_gap2", 640'(hs_q[2] - hs_q[1]), 640'(3));
      chk("rate_done_cycle", 640'(done_cyc - hs_q[2]), 640'(1));
    end
    chk("rate_count", 640'(beat_count), 640'(b0 + 3));

    // Backpressure: beat held stable, second descriptor held off, accepted on done cycle.
    d0 = done_seen;
    tready = 1'b0;
    send_desc(1'b1, 4'd9, 6'd5, 16'h0000, 10'd2, 1'b1);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tvalid) begin got = 1; break; end
    end
    chk("bp_tvalid_seen", 640'(got), 640'(1'b1));
    snap_data = {75'b0, 480'b0, 32'hA0};
    snap_data[TXW-1:DATAW] = {64'h20, 2'b11, 9'd0};
    snap_data[DATAW-1:0] = mem_word(16'h0000);
    snap_dest = 4'd9;
    snap_last = 1'b0;
    @(posedge clk); #1;
    desc_type = 1'b0; desc_node = 4'd7; desc_dpe = 6'd0; desc_base = 16'h0020;
    desc_len = 10'd1; desc_last = 1'b1; desc_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_tvalid", 640'(tvalid), 640'(1'b1));
      chk("bp_tdata", 640'(tdata), 640'(snap_data));
      chk("bp_tdest", 640'(tdest), 640'(snap_dest));
      chk("bp_tlast", 640'(tlast), 640'(snap_last));
      chk("bp_desc_ready", 640'(desc_ready), 640'(1'b0));
    end
    @(posedge clk); #1 tready = 1'b1;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (desc_ready) begin got = 1; break; end
    end
    chk("bp_accept_with_done", 640'({got, done}), 640'(2'b11));
    @(posedge clk); #1 desc_valid = 1'b0;
    wait_idle();
    chk("bp_done_count", 640'(done_seen - d0), 640'(2));

    // Zero-length final descriptor: no beats, done one cycle after acceptance.
    d0 = done_seen;
    b0 = int'(model_cnt);
    hs_q.delete();
    send_desc(1'b1, 4'd4, 6'd0, 16'h0100, 10'd0, 1'b1);
    wait_idle();
    chk("len0_done_count", 640'(done_seen - d0), 640'(1));
    chk("len0_done_cycle", 640'(done_cyc - acc_cyc), 640'(1));
    chk("len0_no_beats", 640'(hs_q.size()), 640'(0));
    chk("len0_count", 640'(beat_count), 640'(b0));

    // Reset while a beat is stalled in SEND.
    tready = 1'b0;
    send_desc(1'b1, 4'd6, 6'd1, 16'h0040, 10'd4, 1'b1);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tvalid) begin got = 1; break; end
    end
    chk("rst_mid_tvalid_seen", 640'(got), 640'(1'b1));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_tvalid", 640'(tvalid), 640'(1'b0));
    chk("rst_mid_busy", 640'(busy), 640'(1'b0));
    chk("rst_mid_desc_ready", 640'(desc_ready), 640'(1'b1));
    chk("rst_mid_beat_count", 640'(beat_count), 640'(0));
    chk("rst_mid_done", 640'(done), 640'(1'b0));
    @(posedge clk); #1;
    rst = 1'b0;
    tready = 1'b1;
    d0 = done_seen;
    hs_q.delete();
    repeat (20) @(posedge clk);
    #1;
    chk("rst_mid_abandoned", 640'(hs_q.size()), 640'(0));
    chk("rst_mid_no_done", 640'(done_seen - d0), 640'(0));

    // Randomized descriptors with random backpressure.
    stop_rand = 0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          logic [9:0] ln;
          ln = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 70)) : 10'($urandom_range(0, 12));
          send_desc(1'($urandom), 4'($urandom), 6'($urandom), 16'($urandom), ln, 1'($urandom));
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 8)) @(posedge clk);
        end
        stop_rand = 1;
      end
      begin
        while (!stop_rand) begin
          @(posedge clk); #1;
          tready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    tready = 1'b1;
    wait_idle();
    chk("rand_drained", 640'(exp_q.size()), 640'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
